// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Sequential ALU with registered results and start/busy/done
//               handshake. It runs single-cycle logic, arithmetic and shift
//               ops, plus iterative shift-add multiply and restoring divide.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] RY,
    input  logic [WIDTH-1:0] RX,
    input  logic [3:0]       Sel_ALU,
    output logic [WIDTH-1:0] R0,
    output logic [WIDTH-1:0] R1,
    output logic [2:0]       Flags,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_AND = 4'b0010;
    localparam logic [3:0] c_OP_OR  = 4'b0011;
    localparam logic [3:0] c_OP_XOR = 4'b0100;
    localparam logic [3:0] c_OP_NOT = 4'b0101;
    localparam logic [3:0] c_OP_SHL = 4'b0110;
    localparam logic [3:0] c_OP_SHR = 4'b0111;
    localparam logic [3:0] c_OP_MUL = 4'b1000;
    localparam logic [3:0] c_OP_DIV = 4'b1001;

    localparam logic [SHW-1:0] c_CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] c_CNT_ONE  = SHW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_r0;
    logic [WIDTH-1:0] r_r1;
    logic [2:0]       r_flags;
    logic             r_done;
    logic [SHW-1:0]   r_cnt;
    logic             r_is_div;
    // r_hi: running high product / partial remainder
    // r_lo: multiplier being consumed / dividend shifting into quotient
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opd;

    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [SHW-1:0]   w_sh;
    logic             w_div0;
    logic             w_iter_op;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shifted;
    logic [WIDTH-1:0] w_div_trial;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic [2:0]       w_fin_flags;

    assign w_sh      = RX[SHW-1:0];
    assign w_div0    = (Sel_ALU == c_OP_DIV) && (RX == '0);
    assign w_iter_op = (Sel_ALU == c_OP_MUL) || ((Sel_ALU == c_OP_DIV) && (RX != '0));

    // Shifts run one bit wider so the last bit shifted out lands in the carry
    assign w_shl = {1'b0, RY} << w_sh;
    assign w_shr = {RY, 1'b0} >> w_sh;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        case (Sel_ALU)
            c_OP_ADD: {w_c, w_res} = {1'b0, RY} + {1'b0, RX};
            c_OP_SUB: begin
                w_res = RY - RX;
                w_c   = (RY < RX);
            end
            c_OP_AND: w_res = RY & RX;
            c_OP_OR:  w_res = RY | RX;
            c_OP_XOR: w_res = RY ^ RX;
            c_OP_NOT: w_res = ~RY;
            c_OP_SHL: {w_c, w_res} = w_shl;
            c_OP_SHR: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            default: begin
                w_res = '0;
                w_c   = 1'b0;
            end
        endcase
    end

    // One shift-add or one restoring-divide step per iteration
    assign w_mul_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : {(WIDTH+1){1'b0}});
    assign w_div_shifted = {r_hi, r_lo[WIDTH-1]};
    assign w_div_ge      = (w_div_shifted >= {1'b0, r_opd});
    assign w_div_trial   = w_div_shifted[WIDTH-1:0] - r_opd;

    always_comb begin
        w_step_hi   = '0;
        w_step_lo   = '0;
        w_fin_flags = 3'b000;
        if (r_is_div) begin
            w_step_hi   = w_div_ge ? w_div_trial : w_div_shifted[WIDTH-1:0];
            w_step_lo   = {r_lo[WIDTH-2:0], w_div_ge};
            w_fin_flags = {1'b0, (w_step_lo == '0), 1'b0};
        end else begin
            w_step_hi   = w_mul_sum[WIDTH:1];
            w_step_lo   = {w_mul_sum[0], r_lo[WIDTH-1:1]};
            w_fin_flags = {(w_step_hi != '0),
                           ({w_step_hi, w_step_lo} == '0),
                           w_step_hi[WIDTH-1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_iter_op ? S_ITER : S_DONE;
                end
            end
            S_ITER: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r0     <= '0;
            r_r1     <= '0;
            r_flags  <= 3'b000;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opd    <= '0;
        end else begin
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_iter_op) begin
                            r_opd    <= RX;
                            r_hi     <= '0;
                            r_lo     <= RY;
                            r_is_div <= (Sel_ALU == c_OP_DIV);
                            r_cnt    <= '0;
                        end else if (w_div0) begin
                            r_r0    <= '1;
                            r_r1    <= RY;
                            r_flags <= 3'b100;
                        end else begin
                            r_r0    <= w_res;
                            r_r1    <= '0;
                            r_flags <= {w_c, (w_res == '0), w_res[WIDTH-1]};
                        end
                    end
                end
                S_ITER: begin
                    r_hi  <= w_step_hi;
                    r_lo  <= w_step_lo;
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        r_r1    <= w_step_hi;
                        r_r0    <= w_step_lo;
                        r_flags <= w_fin_flags;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign R0    = r_r0;
    assign R1    = r_r1;
    assign Flags = r_flags;
    assign busy  = (r_state == S_ITER);
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq: directed literal cases plus
//               randomized traffic compared each cycle to a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] RY;
    logic [W-1:0] RX;
    logic [3:0]   Sel_ALU;
    logic [W-1:0] R0;
    logic [W-1:0] R1;
    logic [2:0]   Flags;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    bit en_cmp = 1'b0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .RY      (RY),
        .RX      (RX),
        .Sel_ALU (Sel_ALU),
        .R0      (R0),
        .R1      (R1),
        .Flags   (Flags),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Reference arithmetic straight from the opcode definitions
    function automatic void ref_op(input int op, input int a, input int b,
                                   output int r0, output int r1, output int fl);
        int mask, s, c, p;
        mask = (1 << W) - 1;
        c = 0; r0 = 0; r1 = 0;
        case (op)
            0: begin s = a + b; r0 = s & mask; c = s >> W; end
            1: begin r0 = (a - b) & mask; c = (a < b) ? 1 : 0; end
            2: r0 = a & b;
            3: r0 = a | b;
            4: r0 = a ^ b;
            5: r0 = (~a) & mask;
            6: begin s = b % W; r0 = (a << s) & mask; c = (s == 0) ? 0 : ((a >> (W - s)) & 1); end
            7: begin s = b % W; r0 = a >> s; c = (s == 0) ? 0 : ((a >> (s - 1)) & 1); end
            8: begin
                p = a * b; r0 = p & mask; r1 = p >> W;
                fl = ((r1 != 0) ? 4 : 0) + ((p == 0) ? 2 : 0) + ((r1 >> (W - 1)) & 1);
                return;
            end
            9: begin
                if (b == 0) begin r0 = mask; r1 = a; fl = 4; end
                else begin r0 = a / b; r1 = a % b; fl = (r0 == 0) ? 2 : 0; end
                return;
            end
            default: r0 = 0;
        endcase
        fl = c * 4 + ((r0 == 0) ? 2 : 0) + ((r0 >> (W - 1)) & 1);
    endfunction

    // Timeline model: edge numbers at which result, busy and done must appear
    int k = 0, next_acc = 0, res_cyc = -100, done_cyc = -100, busy_s = 0, busy_e = 0;
    int p_r0 = 0, p_r1 = 0, p_fl = 0, e_r0 = 0, e_r1 = 0, e_fl = 0;

    always @(posedge clk or posedge rst) begin
        int lat;
        bit iter;
        if (rst) begin
            k = 0; next_acc = 0; res_cyc = -100; done_cyc = -100;
            busy_s = 0; busy_e = 0; e_r0 = 0; e_r1 = 0; e_fl = 0;
        end else begin
            k++;
            if (k >= next_acc && start === 1'b1) begin
                ref_op(int'(Sel_ALU), int'(RY), int'(RX), p_r0, p_r1, p_fl);
                iter     = (Sel_ALU == 4'd8) || (Sel_ALU == 4'd9 && RX != 0);
                lat      = iter ? W + 1 : 1;
                res_cyc  = k + (iter ? W : 0);
                done_cyc = k + lat;
                busy_s   = k;
                busy_e   = iter ? k + W : k;
                next_acc = k + lat + 1;
            end
            if (k == res_cyc) begin
                e_r0 = p_r0; e_r1 = p_r1; e_fl = p_fl;
            end
        end
    end

    always @(negedge clk) begin
        if (en_cmp) begin
            chk("cyc_done",  done,  (k == done_cyc) ? 1 : 0);
            chk("cyc_busy",  busy,  (k >= busy_s && k < busy_e) ? 1 : 0);
            chk("cyc_R0",    R0,    e_r0);
            chk("cyc_R1",    R1,    e_r1);
            chk("cyc_Flags", Flags, e_fl);
        end
    end

    task automatic do_op(input string nm, input logic [3:0] op, input int a, input int b,
                         input int e0, input int e1, input int efl,
                         input int elat, input int ebusy, input bit wiggle);
        int n, nb;
        @(negedge clk); #2;
        Sel_ALU = op; RY = W'(a); RX = W'(b); start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        nb = busy ? 1 : 0;
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (wiggle) begin RX = W'($urandom); Sel_ALU = 4'($urandom); end
            if (done === 1'b1) break;
            if (busy === 1'b1) nb++;
        end
        chk({nm, "_latency"}, n, elat);
        chk({nm, "_busycyc"}, nb, ebusy);
        chk({nm, "_R0"}, R0, e0);
        chk({nm, "_R1"}, R1, e1);
        chk({nm, "_Flags"}, Flags, efl);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; RY = '0; RX = '0; Sel_ALU = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_R0", R0, 0);
        chk("rst_R1", R1, 0);
        chk("rst_Flags", Flags, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk); #2;
        rst = 1'b0;
        en_cmp = 1'b1;

        do_op("add44",   4'd0,  4,   4,   8,    0,   3'b000, 1, 0, 1'b0);
        do_op("add255",  4'd0,  255, 1,   0,    0,   3'b110, 1, 0, 1'b0);
        do_op("sub45",   4'd1,  4,   5,   255,  0,   3'b101, 1, 0, 1'b0);
        do_op("mul200",  4'd8,  200, 3,   88,   2,   3'b100, 9, 8, 1'b1);
        do_op("div10",   4'd9,  10,  3,   3,    1,   3'b000, 9, 8, 1'b1);
        do_op("div0",    4'd9,  7,   0,   255,  7,   3'b100, 1, 0, 1'b0);
        do_op("shl81",   4'd6,  129, 1,   2,    0,   3'b100, 1, 0, 1'b0);
        do_op("shr81",   4'd7,  129, 0,   129,  0,   3'b001, 1, 0, 1'b0);
        do_op("div5by9", 4'd9,  5,   9,   0,    5,   3'b010, 9, 8, 1'b0);
        do_op("op15",    4'd15, 77,  9,   0,    0,   3'b010, 1, 0, 1'b0);
        do_op("mulmax",  4'd8,  255, 255, 1,    254, 3'b101, 9, 8, 1'b0);

        // Reset during the fourth iteration of a multiply
        @(negedge clk); #2;
        Sel_ALU = 4'd8; RY = 8'd200; RX = 8'd3; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort_R0", R0, 0);
        chk("abort_R1", R1, 0);
        chk("abort_Flags", Flags, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("abort_nodone", done, 0);
        end
        do_op("add21", 4'd0, 2, 1, 3, 0, 3'b000, 1, 0, 1'b0);

        // Randomized traffic, including held start and occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #2;
            rst     = ($urandom % 400) == 0;
            start   = ($urandom % 3) != 0;
            Sel_ALU = 4'($urandom);
            RY      = W'($urandom);
            RX      = (($urandom % 8) == 0) ? '0 : W'($urandom);
        end
        @(negedge clk); #2;
        rst = 1'b0; start = 1'b0;
        repeat (2 * W + 4) @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
